uart_rx_byte: RTL and testbench

//  Receives 8N1 asynchronous serial data on the board rx pin and presents each

---
 rtl/uart_rx_byte.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
//   Receives asynchronous serial frames on rx and presents each byte on a
//   valid/ready port. The line goes through a two-flop synchronizer. Bits are
//   sampled in the middle of each bit period. A short low glitch on an idle
//   line is rejected. A low stop bit pulses frame_err and the receiver waits
//   for the line to return high. A byte that arrives while the previous one is
//   still unconsumed replaces it and pulses overrun.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     undefined : 8N1 frames, parity_err tied low, PARITY_ODD ignored
//     defined   : 8 data + 1 parity + 1 stop; parity mismatch pulses
//                 parity_err at the stop sample and the byte is dropped
//
// Parameters
//   CLK_HZ      system clock frequency in Hz
//   BAUD        line rate in bit/s (CLK_HZ/BAUD must be >= 4)
//   PARITY_ODD  1 = odd parity, 0 = even parity (parity build only)
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   rx          serial line, idles high, asynchronous to clk
//   data[7:0]   received byte, LSB first on the wire
//   valid       data holds an unconsumed byte
//   ready       consumer takes data when valid & ready
//   busy        a frame is in progress
//   frame_err   1-cycle pulse: stop bit sampled low
//   parity_err  1-cycle pulse: parity mismatch
//   overrun     1-cycle pulse: new byte landed while valid & !ready
// -----------------------------------------------------------------------------
module uart_rx_byte #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_cpb_check
      $error("uart_rx_byte: CLK_HZ/BAUD must be at least 4");
    end
  endgenerate

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  logic             sync1_q, sync2_q;
  logic             rx_s;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             frame_err_q;
  logic             overrun_q;
  logic             tick;
  logic             deliver;
  logic             ferr_now;

  // Synchronizer flops reset to the idle line level so reset release never
  // looks like a start bit.
  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // design samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;
  assign tick = (cnt_q == '0);

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic perr_now;
  logic parity_err_q;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    deliver  = 1'b0;
    ferr_now = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_now  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        // Half-period load puts every later sample in the middle of a bit.
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = HALF_RELOAD;
        end
      end
      S_START: begin
        if (tick) begin
          if (!rx_s) begin
            state_d  = S_DATA;
            cnt_d    = FULL_RELOAD;
            bitcnt_d = 3'd0;
          end else begin
            state_d = S_IDLE;  // line already high again: glitch, no error
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d  = {rx_s, shift_q[7:1]};  // LSB arrives first
          cnt_d    = FULL_RELOAD;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          par_bad_d = (rx_s != ((^shift_q) ^ PARITY_ODD));
          cnt_d     = FULL_RELOAD;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
`ifdef UART_RX_PARITY_EN
          perr_now = par_bad_q;
`endif
          if (rx_s) begin
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            deliver = !par_bad_q;
`else
            deliver = 1'b1;
`endif
          end else begin
            ferr_now = 1'b1;
            state_d  = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_BREAK: begin
        // Hold off restarts until the line has genuinely returned high.
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bitcnt_q    <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      frame_err_q <= ferr_now;
      // Newest byte wins; overrun flags the one that was never consumed.
      overrun_q   <= deliver & valid_q & ~ready;
      if (deliver) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= perr_now;
    end
  end
  assign parity_err = parity_err_q;
`else
  // PARITY_ODD has no effect in the 8N1 build.
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
  assign parity_err        = 1'b0;
`endif

  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_byte
//   Drives serial frames (directed scenarios plus randomized traffic) into
//   uart_rx_byte. A cycle-indexed timeline of expected busy/pulse/delivery
//   events is built from frame timing arithmetic when each frame is sent, and
//   a single compare process checks every DUT output on every cycle against
//   it, with a small port model for the valid/ready handshake.
//   Build with +define+UART_RX_PARITY_EN to exercise the parity frame format.
// -----------------------------------------------------------------------------
module tb_uart_rx_byte;

  localparam int CPB  = 10;           // 1 MHz / 100 kbaud
  localparam bit PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int FB      = 11;        // start + 8 data + parity + stop
  localparam int LAT_LIT = 108;       // 2 sync + 5 half-bit + 100 + 1 register
`else
  localparam int FB      = 10;        // start + 8 data + stop
  localparam int LAT_LIT = 98;        // 2 sync + 5 half-bit + 90 + 1 register
`endif
  // Cycles from the first low rx cycle to the cycle the result is visible.
  localparam int LAT  = 2 + CPB / 2 + (FB - 1) * CPB + 1;
  localparam int MAXC = 40000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, busy, frame_err, parity_err, overrun;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit rand_ready = 1'b0;

  // Expected timeline, indexed by cycle number.
  bit         exp_busy [MAXC];
  bit         ev_del   [MAXC];
  logic [7:0] ev_byte  [MAXC];
  bit         ev_ferr  [MAXC];
  bit         ev_perr  [MAXC];

  // Output-port model and observation statistics.
  bit         m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         ready_prev = 1'b0;
  bit         prev_valid = 1'b0;
  int         rise_cycle = 0;
  logic [7:0] rise_data = 8'h00;
  int         rise_cnt = 0, valid_cycles = 0, ferr_cnt = 0, perr_cnt = 0, ovr_cnt = 0;

  uart_rx_byte #(
    .CLK_HZ    (1_000_000),
    .BAUD      (100_000),
    .PARITY_ODD(PODD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- compare
  always @(negedge clk) begin
    bit         e_ovr, e_busy, e_ferr, e_perr;
    int         c;
    c      = cyc;
    e_ovr  = 1'b0;
    e_busy = 1'b0;
    e_ferr = 1'b0;
    e_perr = 1'b0;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
    end else if (c < MAXC) begin
      if (ev_del[c]) begin
        e_ovr   = m_valid & ~ready_prev;
        m_data  = ev_byte[c];
        m_valid = 1'b1;
      end else if (m_valid && ready_prev) begin
        m_valid = 1'b0;
      end
      e_busy = exp_busy[c];
      e_ferr = ev_ferr[c];
      e_perr = ev_perr[c];
    end
    check("valid", 32'(valid), 32'(m_valid));
    check("data", 32'(data), 32'(m_data));
    check("busy", 32'(busy), 32'(e_busy));
    check("frame_err", 32'(frame_err), 32'(e_ferr));
    check("parity_err", 32'(parity_err), 32'(e_perr));
    check("overrun", 32'(overrun), 32'(e_ovr));
    ready_prev = ready;
    if (valid === 1'b1 && !prev_valid) begin
      rise_cycle = c;
      rise_data  = data;
      rise_cnt++;
    end
    if (valid === 1'b1) valid_cycles++;
    if (frame_err === 1'b1) ferr_cnt++;
    if (parity_err === 1'b1) perr_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
    prev_valid = (valid === 1'b1);
  end

  // -------------------------------------------------------------- stimulus
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic drive(input bit b);
    @(posedge clk);
    #1;
    rx = b;
  endtask

  task automatic drive_n(input bit b, input int k);
    for (int i = 0; i < k; i++) drive(b);
  endtask

  task automatic mark_busy(input int first, input int last);
    for (int i = first; i <= last; i++) if (i < MAXC) exp_busy[i] = 1'b1;
  endtask

  // Frame whose rx start bit begins in cycle n. rx_s goes low at n+2; the
  // stop sample is taken CPB/2 + (FB-1)*CPB later and the result shows one
  // cycle after that. A failed stop keeps the receiver busy until it has seen
  // the line high again, two cycles after rx rises at n + FB*CPB + hold.
  task automatic sched_frame(input int n, input logic [7:0] d, input bit stop_ok,
                             input bit par_ok, input int hold);
    int d_cyc;
    d_cyc = n + LAT;
    if (stop_ok) mark_busy(n + 3, d_cyc - 1);
    else         mark_busy(n + 3, n + FB * CPB + hold + 2);
    if (d_cyc < MAXC) begin
      if (stop_ok && par_ok) begin
        ev_del[d_cyc]  = 1'b1;
        ev_byte[d_cyc] = d;
      end
      if (!stop_ok) ev_ferr[d_cyc] = 1'b1;
      if (!par_ok)  ev_perr[d_cyc] = 1'b1;
    end
  endtask

  task automatic clear_from(input int r);
    for (int i = r; i < MAXC; i++) begin
      exp_busy[i] = 1'b0;
      ev_del[i]   = 1'b0;
      ev_ferr[i]  = 1'b0;
      ev_perr[i]  = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok,
                            input int hold, output int n);
    bit pbit;
    pbit = (^d) ^ PODD ^ ~par_ok;
    drive(1'b0);
    n = cyc;
    sched_frame(n, d, stop_ok, par_ok, hold);
    drive_n(1'b0, CPB - 1);
    for (int k = 0; k < 8; k++) drive_n(d[k], CPB);
`ifdef UART_RX_PARITY_EN
    drive_n(pbit, CPB);
`endif
    drive_n(stop_ok, CPB);
    if (!stop_ok) begin
      drive_n(1'b0, hold);
      drive(1'b1);
    end
  endtask

  // A low pulse of len cycles (1..4) is back high before the mid-start sample.
  task automatic glitch(input int len, output int n);
    drive(1'b0);
    n = cyc;
    mark_busy(n + 3, n + 2 + CPB / 2);
    drive_n(1'b0, len - 1);
    drive_n(1'b1, 12 - len);
  endtask

  initial begin
    int n, v0, f0, o0, rc0, r;
`ifdef UART_RX_PARITY_EN
    int p0;
`endif
    repeat (4) @(posedge clk);
    #1;
    rst   = 1'b0;
    ready = 1'b1;
    drive_n(1'b1, 20);

    // 1: single byte, latency pinned to a hand-computed literal
    v0 = valid_cycles;
    f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, 1'b1, 0, n);
    drive_n(1'b1, 5);
    check("t1_latency", 32'(rise_cycle - n), 32'(LAT_LIT));
    check("t1_data", 32'(rise_data), 32'h0000_00A5);
    check("t1_valid_cycles", 32'(valid_cycles - v0), 32'd1);
    check("t1_no_ferr", 32'(ferr_cnt - f0), 32'd0);

    // 2: short glitch on idle line
    v0 = valid_cycles;
    f0 = ferr_cnt;
    glitch(3, n);
    drive_n(1'b1, 10);
    check("t2_no_valid", 32'(valid_cycles - v0), 32'd0);
    check("t2_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("t2_idle", 32'(busy), 32'd0);

    // 3: bad stop with 30-cycle break, then a clean byte
    v0 = valid_cycles;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b1, 30, n);
    check("t3_ferr_once", 32'(ferr_cnt - f0), 32'd1);
    check("t3_no_valid", 32'(valid_cycles - v0), 32'd0);
    drive_n(1'b1, 3);
    send_frame(8'h55, 1'b1, 1'b1, 0, n);
    drive_n(1'b1, 3);
    check("t3_data", 32'(rise_data), 32'h0000_0055);
    check("t3_latency", 32'(rise_cycle - n), 32'(LAT_LIT));

    // 4: overrun while not ready
    ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, 1'b1, 0, n);
    drive_n(1'b1, 2);
    check("t4_hold_valid", 32'(valid), 32'd1);
    check("t4_hold_data", 32'(data), 32'h0000_0011);
    send_frame(8'h22, 1'b1, 1'b1, 0, n);
    check("t4_overrun", 32'(ovr_cnt - o0), 32'd1);
    check("t4_new_data", 32'(data), 32'h0000_0022);
    check("t4_still_valid", 32'(valid), 32'd1);
    ready = 1'b1;
    drive(1'b1);
    check("t4_valid_drop", 32'(valid), 32'd0);
    drive_n(1'b1, 5);

    // 5: reset in the middle of the data bits of 0xFF
    drive(1'b0);
    n = cyc;
    sched_frame(n, 8'hFF, 1'b1, 1'b1, 0);
    drive_n(1'b0, CPB - 1);
    drive_n(1'b1, 35);
    @(posedge clk);
    #1;
    rst = 1'b1;
    rx  = 1'b1;
    r   = cyc;
    clear_from(r);
    drive_n(1'b1, 3);
    check("t5_rst_data", 32'(data), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_n(1'b1, 5);
    rc0 = rise_cnt;
    send_frame(8'h0F, 1'b1, 1'b1, 0, n);
    drive_n(1'b1, 3);
    check("t5_data", 32'(rise_data), 32'h0000_000F);
    check("t5_one_byte", 32'(rise_cnt - rc0), 32'd1);

`ifdef UART_RX_PARITY_EN
    // 6: even parity, good then bad parity bit
    send_frame(8'h07, 1'b1, 1'b1, 0, n);
    drive_n(1'b1, 3);
    check("t6_data", 32'(rise_data), 32'h0000_0007);
    v0 = valid_cycles;
    p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b0, 0, n);
    drive_n(1'b1, 3);
    check("t6_perr", 32'(perr_cnt - p0), 32'd1);
    check("t6_no_valid", 32'(valid_cycles - v0), 32'd0);
`endif

    // Randomized traffic with random ready
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      int  mode;
      bit  pok;
      mode = int'($urandom_range(0, 19));
`ifdef UART_RX_PARITY_EN
      pok = ($urandom_range(0, 4) != 0);
`else
      pok = 1'b1;
`endif
      if (mode < 2)
        send_frame(8'($urandom), 1'b0, pok, int'($urandom_range(0, 25)), n);
      else if (mode < 4)
        glitch(int'($urandom_range(1, 4)), n);
      else
        send_frame(8'($urandom), 1'b1, pok, 0, n);
      drive_n(1'b1, int'($urandom_range(0, 15)));
    end
    rand_ready = 1'b0;
    ready = 1'b1;
    drive_n(1'b1, 150);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(MAXC * 10 - 100);
    $display("FAIL watchdog: simulation did not finish within %0d cycles", MAXC);
    $fatal(1, "watchdog expired");
  end

endmodule
